// File: rtl/dht11_pkg.sv
// dht11_pkg: shared state encoding, frame field positions and limits for the
// DHT11 frame decoder.
`default_nettype none

package dht11_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_CHECK   = 3'd1;
   localparam state_t S_SCALE   = 3'd2;
   localparam state_t S_CONVERT = 3'd3;
   localparam state_t S_DONE    = 3'd4;

   localparam int HUM_INT_LSB  = 32;
   localparam int HUM_DEC_LSB  = 24;
   localparam int TMP_INT_LSB  = 16;
   localparam int TMP_DEC_LSB  = 8;
   localparam int CSUM_LSB     = 0;
   localparam int TMP_NEG_BIT  = 15;

   localparam logic [7:0] MAX_FIELD = 8'd99;

   localparam int BIN_W_DEFAULT = 14;
   localparam int CONV_CYCLES   = BIN_W_DEFAULT;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to packed BCD, one bit per clock.
// done is high during the final shift; bcd holds the result from the next cycle.
`default_nettype none

module bin2bcd_seq #(
   parameter int BIN_W      = 14,
   parameter int BCD_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [BIN_W-1:0]        bin,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   localparam int SR_W = 4*BCD_DIGITS + BIN_W;
   localparam int CW   = $clog2(BIN_W + 1);
   localparam logic [CW-1:0] c_steps = CW'(BIN_W);

   logic [SR_W-1:0] r_sr;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic [SR_W-1:0] w_adj;

   always_comb begin
      w_adj = r_sr;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (r_sr[BIN_W+4*d +: 4] >= 4'd5) begin
            w_adj[BIN_W+4*d +: 4] = r_sr[BIN_W+4*d +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start) begin
         r_sr   <= {{(4*BCD_DIGITS){1'b0}}, bin};
         r_cnt  <= c_steps;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_sr  <= {w_adj[SR_W-2:0], 1'b0};
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CW'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign done = r_busy && (r_cnt == CW'(1));
   assign bcd  = r_sr[SR_W-1 -: 4*BCD_DIGITS];

endmodule

`default_nettype wire

// File: rtl/dht11_frame_decode.sv
// dht11_frame_decode: validates DHT11 frames, scales the selected reading to
// hundredths and emits packed BCD + sign. Macro DHT11_ERR_CNT_EN enables err_cnt.
`default_nettype none

module dht11_frame_decode
   import dht11_pkg::*;
#(
   parameter int BIN_W      = 14,
   parameter int BCD_DIGITS = 4,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [39:0]             frame_in,
   input  logic                    frame_valid,
   input  logic                    sel,
   output logic [4*BCD_DIGITS-1:0] data,
   output logic                    sign,
   output logic                    data_valid,
   output logic                    csum_err,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   state_t                  r_state;
   logic [39:0]             r_frame;
   logic                    r_sel_new;
   logic                    r_sel;
   logic [39:0]             r_pend_frame;
   logic                    r_pend_valid;
   logic                    r_good_valid;
   logic [7:0]              r_good_hint;
   logic [6:0]              r_good_hdec;
   logic [7:0]              r_good_tint;
   logic [7:0]              r_good_tdec;
   logic                    r_sign_work;
   logic [4*BCD_DIGITS-1:0] r_data;
   logic                    r_sign;
   logic                    r_data_valid;
   logic                    r_csum_err;

   logic [7:0]              w_sum;
   logic [7:0]              w_int_chk;
   logic [6:0]              w_dec_chk;
   logic                    w_reject;
   logic [7:0]              w_int_s;
   logic [6:0]              w_dec_s;
   logic [BIN_W-1:0]        w_int_ext;
   logic [BIN_W-1:0]        w_value;
   logic                    w_conv_start;
   logic                    w_conv_done;
   logic [4*BCD_DIGITS-1:0] w_bcd;

   // Modulo-256 checksum over the four data bytes, range check on the selected pair.
   assign w_sum = r_frame[HUM_INT_LSB +: 8] + r_frame[HUM_DEC_LSB +: 8]
                + r_frame[TMP_INT_LSB +: 8] + r_frame[TMP_DEC_LSB +: 8];
   assign w_int_chk = r_sel_new ? r_frame[HUM_INT_LSB +: 8] : r_frame[TMP_INT_LSB +: 8];
   assign w_dec_chk = r_sel_new ? r_frame[HUM_DEC_LSB +: 7] : r_frame[TMP_DEC_LSB +: 7];
   assign w_reject  = (w_sum != r_frame[CSUM_LSB +: 8])
                   || (w_int_chk > MAX_FIELD)
                   || ({1'b0, w_dec_chk} > MAX_FIELD);

   // int*100 built as int*64 + int*32 + int*4.
   assign w_int_s   = r_sel ? r_good_hint : r_good_tint;
   assign w_dec_s   = r_sel ? r_good_hdec : r_good_tdec[6:0];
   assign w_int_ext = BIN_W'(w_int_s);
   assign w_value   = (w_int_ext << 6) + (w_int_ext << 5) + (w_int_ext << 2)
                    + BIN_W'(w_dec_s);

   assign w_conv_start = (r_state == S_SCALE);

   bin2bcd_seq #(
      .BIN_W      (BIN_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bin2bcd (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .start (w_conv_start),
      .bin   (w_value),
      .done  (w_conv_done),
      .bcd   (w_bcd)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state      <= S_IDLE;
         r_frame      <= '0;
         r_sel_new    <= 1'b0;
         r_sel        <= 1'b0;
         r_pend_frame <= '0;
         r_pend_valid <= 1'b0;
         r_good_valid <= 1'b0;
         r_good_hint  <= '0;
         r_good_hdec  <= '0;
         r_good_tint  <= '0;
         r_good_tdec  <= '0;
         r_sign_work  <= 1'b0;
         r_data       <= '0;
         r_sign       <= 1'b0;
         r_data_valid <= 1'b0;
         r_csum_err   <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_csum_err   <= 1'b0;

         if (frame_valid && (r_state != S_IDLE)) begin
            r_pend_frame <= frame_in;
            r_pend_valid <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (frame_valid) begin
                  r_frame      <= frame_in;
                  r_sel_new    <= sel;
                  r_pend_valid <= 1'b0;
                  r_state      <= S_CHECK;
               end else if (r_pend_valid) begin
                  r_frame      <= r_pend_frame;
                  r_sel_new    <= sel;
                  r_pend_valid <= 1'b0;
                  r_state      <= S_CHECK;
               end else if (r_good_valid && (sel != r_sel)) begin
                  r_sel   <= sel;
                  r_state <= S_SCALE;
               end
            end
            S_CHECK: begin
               if (w_reject) begin
                  r_csum_err <= 1'b1;
                  r_state    <= S_IDLE;
               end else begin
                  r_good_hint  <= r_frame[HUM_INT_LSB +: 8];
                  r_good_hdec  <= r_frame[HUM_DEC_LSB +: 7];
                  r_good_tint  <= r_frame[TMP_INT_LSB +: 8];
                  r_good_tdec  <= r_frame[TMP_DEC_LSB +: 8];
                  r_good_valid <= 1'b1;
                  r_sel        <= r_sel_new;
                  r_state      <= S_SCALE;
               end
            end
            S_SCALE: begin
               r_sign_work <= ~r_sel & r_good_tdec[TMP_NEG_BIT-TMP_DEC_LSB];
               r_state     <= S_CONVERT;
            end
            S_CONVERT: begin
               if (w_conv_done) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_data       <= w_bcd;
               r_sign       <= r_sign_work;
               r_data_valid <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef DHT11_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_err_cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_err_cnt <= '0;
      end else if ((r_state == S_CHECK) && w_reject && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

   assign data       = r_data;
   assign sign       = r_sign;
   assign data_valid = r_data_valid;
   assign csum_err   = r_csum_err;

endmodule

`default_nettype wire

// File: tb/tb_dht11_frame_decode.sv
// tb_dht11_frame_decode: directed scoreboard bench for dht11_frame_decode.
`default_nettype none

module tb_dht11_frame_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [39:0] frame_in = '0;
   logic        frame_valid = 1'b0;
   logic        sel = 1'b0;
   logic [15:0] data;
   logic        sign;
   logic        data_valid;
   logic        csum_err;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;
   int exp_errs = 0;
   int lat;
   logic [16:0] exp_q[$];
   logic [16:0] e_mon;

`ifdef DHT11_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam logic [39:0] F_GOOD  = 40'h46_00_18_1A_78;
   localparam logic [39:0] F_BAD   = 40'h46_00_18_1A_77;
   localparam logic [39:0] F_NEG   = 40'h28_00_05_85_B2;
   localparam logic [39:0] F_NEGZ  = 40'h28_00_00_80_A8;
   localparam logic [39:0] F_RINT  = 40'h28_00_64_00_8C;
   localparam logic [39:0] F_RDEC  = 40'h28_00_05_64_91;
   localparam logic [39:0] F_C     = 40'h32_05_17_63_B1;

   dht11_frame_decode dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .sel         (sel),
      .data        (data),
      .sign        (sign),
      .data_valid  (data_valid),
      .csum_err    (csum_err),
      .err_cnt     (err_cnt)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [39:0] f, input logic s);
      int i;
      int d;
      int v;
      logic [15:0] b;
      if (s) begin
         i = int'(f[39:32]);
         d = int'(f[30:24]);
      end else begin
         i = int'(f[23:16]);
         d = int'(f[14:8]);
      end
      v = i * 100 + d;
      b = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      return {(!s && f[15]), b};
   endfunction

   function automatic logic [31:0] exp_cnt();
      if (!CNT_EN) return 32'd0;
      return (exp_errs > 255) ? 32'd255 : 32'(exp_errs);
   endfunction

   always @(negedge clk) begin
      if (data_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_data_valid observed=%0h expected=none", {sign, data});
         end else begin
            e_mon = exp_q.pop_front();
            check("data_sign", {15'b0, sign, data}, {15'b0, e_mon});
         end
      end
   end

   task automatic send(input logic [39:0] f, input logic s);
      @(negedge clk);
      frame_in    = f;
      sel         = s;
      frame_valid = 1'b1;
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
   endtask

   task automatic wait_valid(input int lim, output int n);
      n = 0;
      while (!data_valid && n < lim) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic drain(input int lim);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         @(posedge clk);
         n++;
      end
      check("queue_drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reject(input string tag);
      exp_errs++;
      @(posedge clk);
      #1;
      check({tag, "_csum_err"}, {31'b0, csum_err}, 32'd1);
      check({tag, "_err_cnt"}, {24'b0, err_cnt}, exp_cnt());
      @(posedge clk);
      #1;
      check({tag, "_csum_pulse_end"}, {31'b0, csum_err}, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", {16'b0, data}, 32'd0);
      check("rst_sign", {31'b0, sign}, 32'd0);
      check("rst_valid", {31'b0, data_valid}, 32'd0);
      check("rst_csum", {31'b0, csum_err}, 32'd0);
      check("rst_errcnt", {24'b0, err_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Temperature 24.26, then humidity reconversion on sel change.
      exp_q.push_back(model(F_GOOD, 1'b0));
      send(F_GOOD, 1'b0);
      wait_valid(40, lat);
      check("latency_frame", 32'(lat + 1), 32'd18);
      @(negedge clk);
      sel = 1'b1;
      exp_q.push_back(model(F_GOOD, 1'b1));
      @(posedge clk);
      #1;
      wait_valid(40, lat);
      check("latency_selchg", 32'(lat + 1), 32'd17);
      check("hum_data", {16'b0, data}, 32'h7000);
      @(negedge clk);
      sel = 1'b0;
      exp_q.push_back(model(F_GOOD, 1'b0));
      drain(40);

      // Bad checksum keeps previous output.
      send(F_BAD, 1'b0);
      check_reject("bad_csum");
      repeat (20) @(posedge clk);
      #1;
      check("bad_keeps_data", {16'b0, data}, 32'h2426);

      // Negative temperature and negative zero.
      exp_q.push_back(model(F_NEG, 1'b0));
      send(F_NEG, 1'b0);
      drain(40);
      #1;
      check("neg_data", {15'b0, sign, data}, {15'b0, 1'b1, 16'h0505});
      exp_q.push_back(model(F_NEGZ, 1'b0));
      send(F_NEGZ, 1'b0);
      drain(40);
      #1;
      check("negzero_sign", {31'b0, sign}, 32'd1);

      // Range rejects on integer and decimal.
      send(F_RINT, 1'b0);
      check_reject("range_int");
      send(F_RDEC, 1'b0);
      check_reject("range_dec");

      // sel change mid-conversion is deferred to a reconversion.
      exp_q.push_back(model(F_GOOD, 1'b0));
      exp_q.push_back(model(F_GOOD, 1'b1));
      send(F_GOOD, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      sel = 1'b1;
      drain(80);

      // Pending buffer: latest wins, B never output.
      exp_q.push_back(model(F_GOOD, 1'b1));
      exp_q.push_back(model(F_C, 1'b1));
      send(F_GOOD, 1'b1);
      repeat (4) @(posedge clk);
      send(F_NEG, 1'b1);
      repeat (2) @(posedge clk);
      send(F_C, 1'b1);
      drain(80);
      repeat (25) @(posedge clk);
      #1;
      check("pending_last_data", {16'b0, data}, 32'h5005);

      // Counter saturation.
      for (int k = 0; k < 300; k++) begin
         send(F_BAD, 1'b1);
         exp_errs++;
         repeat (2) @(posedge clk);
      end
      #1;
      check("err_cnt_sat", {24'b0, err_cnt}, exp_cnt());

      // Reset mid-conversion.
      send(F_GOOD, 1'b1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_data", {16'b0, data}, 32'd0);
      check("midrst_sign", {31'b0, sign}, 32'd0);
      check("midrst_valid", {31'b0, data_valid}, 32'd0);
      check("midrst_csum", {31'b0, csum_err}, 32'd0);
      check("midrst_errcnt", {24'b0, err_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(posedge clk);

      exp_q.push_back(model(F_GOOD, 1'b1));
      send(F_GOOD, 1'b1);
      wait_valid(40, lat);
      check("post_rst_latency", 32'(lat + 1), 32'd18);
      drain(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
